reg1_run_monitor: RTL and testbench

REG1_RUN_MONITOR -- requirements
Module: reg1_run_monitor

---
 rtl/reg1_run_monitor_pkg.sv | 9 +
 rtl/reg1_run_fifo.sv | 47 ++++
 rtl/reg1_run_monitor.sv | 106 ++++++++++
 tb/tb_reg1_run_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg1_run_monitor_pkg.sv
// reg1_run_monitor_pkg: shared FSM state and result-entry types for the run monitor
package reg1_run_monitor_pkg;
  localparam int MAX_CNT_W = 16;
  typedef enum logic {IDLE, RUN} state_e;
  typedef struct packed {
    logic [MAX_CNT_W-1:0] len;
    logic                 sat;
  } run_entry_t;
endpackage

// File: rtl/reg1_run_fifo.sv
// reg1_run_fifo: power-of-two result FIFO; a push into a full FIFO lands only alongside a pop
module reg1_run_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_q];
  // pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/reg1_run_monitor.sv
// reg1_run_monitor: measures high runs of din and queues {len, sat}; REG1_RUN_MONITOR_SYNC_EN adds a 2-flop din synchronizer
module reg1_run_monitor
  import reg1_run_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic             run_valid,
  input  logic             run_ready,
  output logic [CNT_W-1:0] run_len,
  output logic             run_sat,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d, ovf_q, ovf_d;
  logic             s_q, push, pop, drop, full, empty;
  run_entry_t       push_e, pop_e;
`ifdef REG1_RUN_MONITOR_SYNC_EN
  logic [1:0] sync_q;
  // two synchronizer stages ahead of the sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      s_q    <= sync_q[1];
    end
  end
`else
  // din registered once to form the sample point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 1'b0;
    else        s_q <= din;
  end
`endif
  // run FSM: start on a high sample, count while high, push on the falling sample
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sat_d   = sat_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (enable && s_q) begin
        state_d = RUN;
        count_d = CNT_W'(1);
        sat_d   = 1'b0;
      end
      RUN: if (!enable || !s_q) begin
        push    = enable;
        state_d = IDLE;
        count_d = '0;
        sat_d   = 1'b0;
      end else begin
        count_d = count_q == CNT_MAX ? count_q : count_q + CNT_W'(1);
        sat_d   = sat_q || count_q == CNT_MAX;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and run counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end
  assign push_e    = '{len: MAX_CNT_W'(count_q), sat: sat_q};
  assign run_valid = !empty;
  assign pop       = run_valid && run_ready;
  assign drop      = push && full && !pop;
  assign run_len   = run_valid ? CNT_W'(pop_e.len) : '0;
  assign run_sat   = run_valid && pop_e.sat;
  assign ovf       = ovf_q;
  // a drop wins over a coincident clear so no loss goes unreported
  always_comb begin
    ovf_d = drop || (ovf_q && !clr_ovf);
  end
  // sticky overflow register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  reg1_run_fifo #(.W($bits(run_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_e),
    .full     (full),
    .pop      (pop),
    .pop_data (pop_e),
    .empty    (empty)
  );
endmodule

// File: tb/tb_reg1_run_monitor.sv
// tb_reg1_run_monitor: table-driven run vectors with a result scoreboard plus hand-written corner sequences
module tb_reg1_run_monitor;
`ifdef REG1_RUN_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic       clk = 0, rst_n = 0, din = 0, enable = 0, clr_ovf = 0, run_ready = 0;
  logic       run_valid, run_sat, ovf;
  logic [7:0] run_len;
  logic       din2 = 0, en2 = 1, clr2 = 0, rdy2 = 1;
  logic       v2, sat2, ovf2;
  logic [3:0] len2;
  typedef struct {int hi; int lo; int exp_len; logic exp_sat;} vec_t;
  typedef struct {int len; logic sat;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_cmp = 0, n_bad = 0, n;

  reg1_run_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .enable(enable), .clr_ovf(clr_ovf),
    .run_valid(run_valid), .run_ready(run_ready), .run_len(run_len), .run_sat(run_sat), .ovf(ovf)
  );
  reg1_run_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .din(din2), .enable(en2), .clr_ovf(clr2),
    .run_valid(v2), .run_ready(rdy2), .run_len(len2), .run_sat(sat2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int hi, input int lo);
    din = 1;
    repeat (hi) tick();
    din = 0;
    repeat (lo) tick();
  endtask

  task automatic expect_res(input int l, input logic s);
    sb.push_back('{len: l, sat: s});
  endtask

  task automatic drain();
    run_ready = 1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_complete", sb.size(), 0);
  endtask

  // scoreboard monitor: every transfer is compared against the oldest expected result
  always @(negedge clk) begin
    if (rst_n) begin
      if (run_valid && run_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("run_len", int'(run_len), mon_e.len);
          chk("run_sat", int'(run_sat), int'(mon_e.sat));
        end
      end else if (!run_valid) begin
        chk("idle_outputs_zero", int'(run_len) + int'(run_sat), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{hi: 5,   lo: 3, exp_len: 5,   exp_sat: 0};
    vecs[1] = '{hi: 1,   lo: 1, exp_len: 1,   exp_sat: 0};
    vecs[2] = '{hi: 2,   lo: 1, exp_len: 2,   exp_sat: 0};
    vecs[3] = '{hi: 10,  lo: 4, exp_len: 10,  exp_sat: 0};
    vecs[4] = '{hi: 255, lo: 2, exp_len: 255, exp_sat: 0};
    vecs[5] = '{hi: 300, lo: 2, exp_len: 255, exp_sat: 1};
    vecs[6] = '{hi: 3,   lo: 6, exp_len: 3,   exp_sat: 0};
    // reset state
    repeat (2) tick();
    chk("rst_valid", int'(run_valid), 0);
    chk("rst_len", int'(run_len), 0);
    chk("rst_sat", int'(run_sat), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1;
    enable = 1;
    tick();
    // push-to-valid latency on a 5-cycle run
    din = 1;
    repeat (5) tick();
    din = 0;
    n = 0;
    while (!run_valid && n < 20) begin
      tick();
      n++;
    end
    chk("fall_to_valid_ticks", n, 2 + LAT);
    chk("first_len", int'(run_len), 5);
    chk("first_sat", int'(run_sat), 0);
    repeat (3) tick();
    chk("hold_len", int'(run_len), 5);
    expect_res(5, 0);
    run_ready = 1;
    tick();
    // table of runs with the consumer always ready
    foreach (vecs[i]) begin
      expect_res(vecs[i].exp_len, vecs[i].exp_sat);
      run(vecs[i].hi, vecs[i].lo);
    end
    repeat (6 + LAT) tick();
    chk("table_results_seen", sb.size(), 0);
    // enable dropped mid-run discards it; the next run is measured cleanly
    din = 1;
    repeat (5) tick();
    enable = 0;
    repeat (2) tick();
    din = 0;
    repeat (6) tick();
    enable = 1;
    expect_res(4, 0);
    run(4, 6 + LAT);
    chk("enable_drop_results", sb.size(), 0);
    // overflow: five runs into a four-entry FIFO with no consumer
    run_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_res(2, 0);
      run(2, 4 + LAT);
    end
    chk("ovf_after_drop", int'(ovf), 1);
    chk("full_valid", int'(run_valid), 1);
    drain();
    tick();
    chk("valid_drops_after_drain", int'(run_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);
    // reset mid-run with two entries queued and ovf still set
    run_ready = 0;
    run(2, 4 + LAT);
    run(2, 4 + LAT);
    chk("two_queued_valid", int'(run_valid), 1);
    din = 1;
    repeat (5) tick();
    rst_n = 0;
    #2;
    chk("midrst_valid", int'(run_valid), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_len", int'(run_len), 0);
    din = 0;
    tick();
    rst_n = 1;
    run_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_no_output", int'(run_valid), 0);
    end
    // drop coinciding with clr_ovf leaves ovf set; a lone clear then clears it
    run_ready = 0;
    for (int i = 0; i < 4; i++) begin
      expect_res(2, 0);
      run(2, 4 + LAT);
    end
    chk("ovf_before_drop", int'(ovf), 0);
    din = 1;
    repeat (2) tick();
    din = 0;
    repeat (1 + LAT) tick();
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_drop_with_clr", int'(ovf), 1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_cleared", int'(ovf), 0);
    drain();
    // saturation boundary on a 4-bit counter instance
    din2 = 1;
    repeat (15) tick();
    din2 = 0;
    n = 0;
    while (!v2 && n < 20) begin
      tick();
      n++;
    end
    chk("cnt4_len15", int'(len2), 15);
    chk("cnt4_sat15", int'(sat2), 0);
    repeat (4) tick();
    din2 = 1;
    repeat (20) tick();
    din2 = 0;
    n = 0;
    while (!v2 && n < 20) begin
      tick();
      n++;
    end
    chk("cnt4_len20", int'(len2), 15);
    chk("cnt4_sat20", int'(sat2), 1);
    repeat (4) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
